// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial WIDTH-bit adder. Operands are captured on an accepted start, then
// fed LSB first, one bit per cycle, through a single full_adder cell. The
// carry is held in a flop between cycles and the sum bits are assembled in a
// shift register. The result (sum, cout) is registered at the last-bit edge
// and held until the next completion.
//
// Parameters:
//   WIDTH  operand/sum width in bits (>= 2)
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request; sampled only in IDLE or DONE
//   a, b   operands, captured when start is accepted
//   cin    carry-in, captured when start is accepted
//   busy   high while in RUN
//   done   one-cycle completion pulse (state DONE)
//   sum    registered result, (a+b+cin) mod 2^WIDTH
//   cout   registered final carry
//   ovf    (only with SERIAL_ADDER_OVF_EN) registered two's-complement
//          signed overflow: carry into MSB XOR carry out of MSB
//
// Build option:
//   SERIAL_ADDER_OVF_EN  adds the ovf output and its register.
//
// Timing: start accepted at edge N, RUN covers edges N+1 .. N+WIDTH, and done
// is high in the cycle after edge N+WIDTH. One add per WIDTH+1 cycles when
// start is held in DONE.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// full_adder
//
// One-bit full adder cell used by serial_adder.
//   a, b, cin  addend bits and carry-in
//   s          sum bit
//   cout       carry-out
// -----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic fa_s;
  logic fa_cout;

  // Start is honoured only where a new operation may begin.
  logic accept;
  logic last_bit;

  assign accept   = start && (state == IDLE || state == DONE);
  assign last_bit = (state == RUN) && (cnt == LAST_BIT);

  full_adder u_full_adder (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (cnt == LAST_BIT) state_next = DONE;
      DONE: state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs come straight from the state register, never from the
  // combinational adder, so they are glitch-free.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // ---------------------------------------------------------------------------
  // Datapath: operand shifters, carry flop, bit counter, sum assembly
  // ---------------------------------------------------------------------------
  // NOTE: the shift registers are plain flops, not a memory array, so they are
  // cleared by reset; that keeps a stale operand from ever reaching the adder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
      carry  <= fa_cout;
      // Stops at LAST_BIT; the next accept reloads it to zero.
      if (!last_bit) cnt <= cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Published result: changes only at the last-bit edge, held otherwise.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (last_bit) begin
      sum  <= {fa_s, sum_sh[WIDTH-1:1]};
      cout <= fa_cout;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // At the MSB, carry holds the carry into the MSB and fa_cout the carry out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (last_bit) begin
      ovf <= carry ^ fa_cout;
    end
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Directed bench for serial_adder (WIDTH=8) with hand-computed expected values.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at
// the same point, away from the active edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and lets the next edge accept it; returns 1 time unit
  // after the acceptance edge, in the first RUN cycle.
  task automatic start_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic vc, input logic [WIDTH-1:0] prev_sum,
                          input logic prev_cout);
    start = 1'b1;
    a     = va;
    b     = vb;
    cin   = vc;
    step();
    start = 1'b0;
    a     = ~va;     // scramble operands: must be ignored during RUN
    b     = ~vb;
    cin   = ~vc;
    check("busy_first", busy, 1'b1);
    check("sum_hold_run", sum, prev_sum);
    check("cout_hold_run", cout, prev_cout);
  endtask

  // Walks the remaining RUN cycles and the completion cycle. If inject is
  // nonzero, a start with a=b=FF is pulsed during RUN cycle 'inject'.
  task automatic finish_op(input string tag, input logic [WIDTH-1:0] exp_sum,
                           input logic exp_cout, input logic exp_ovf,
                           input int inject);
    int busy_ok = 1;
    for (int i = 1; i < WIDTH; i++) begin
      if (inject != 0 && i == inject) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
      end
      step();
      start = 1'b0;
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 0;
    end
    check({tag, "_busy_run"}, busy_ok, 1);
    step();
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_off"}, busy, 1'b0);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, cout, exp_cout);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, ovf, exp_ovf);
`else
    if (exp_ovf === 1'bx) $display("unexpected ovf expectation");
`endif
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("idle_busy", busy, 1'b0);

    // Zero operands: 8 busy cycles, then done.
    start_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    finish_op("zero", 8'h00, 1'b0, 1'b0, 0);
    step();
    check("zero_done_pulse", done, 1'b0);

    // Unsigned wrap with carry out, no signed overflow.
    start_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b0);
    finish_op("ff01", 8'h00, 1'b1, 1'b0, 0);
    step();
    check("ff01_idle_hold_sum", sum, 8'h00);
    check("ff01_idle_hold_cout", cout, 1'b1);

    // Signed overflow without carry out.
    start_op(8'h7F, 8'h01, 1'b0, 8'h00, 1'b1);
    finish_op("7f01", 8'h80, 1'b0, 1'b1, 0);
    step();

    // Carry-in path, then back-to-back start held in DONE.
    start_op(8'hA5, 8'h5A, 1'b1, 8'h80, 1'b0);
    finish_op("a55a", 8'h00, 1'b1, 1'b0, 0);
    start_op(8'h12, 8'h34, 1'b0, 8'h00, 1'b1);
    finish_op("b2b", 8'h46, 1'b0, 1'b0, 0);
    step();

    // Start during RUN is ignored.
    start_op(8'h0F, 8'h01, 1'b0, 8'h46, 1'b0);
    finish_op("ign", 8'h10, 1'b0, 1'b0, 3);
    step();

    // Asynchronous reset mid-RUN.
    start_op(8'hC3, 8'h3C, 1'b1, 8'h10, 1'b0);
    step();
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_sum", sum, 8'h00);
    check("arst_cout", cout, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int spurious = 0;
      for (int i = 0; i < WIDTH + 2; i++) begin
        step();
        if (done !== 1'b0 || busy !== 1'b0) spurious = 1;
      end
      check("arst_no_done", spurious, 0);
    end
    start_op(8'h03, 8'h04, 1'b1, 8'h00, 1'b0);
    finish_op("post_rst", 8'h08, 1'b0, 1'b0, 0);
    step();
    check("post_rst_idle", done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
